bar_mmio_bridge: RTL and testbench

BAR_MMIO_BRIDGE -- requirements
Module: bar_mmio_bridge

---
 rtl/bar_bridge_pkg.sv | 33 +++
 rtl/bar_sync_fifo.sv | 67 ++++++
 rtl/bar_mmio_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_bar_mmio_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bar_bridge_pkg.sv
// Purpose: shared constants for the BAR MMIO bridge (register offsets, fixed read values, status bit positions).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bar_bridge_pkg;

  // The BAR window spans eight 32-bit registers.
  localparam int unsigned WINDOW_BYTES = 32;

  // Byte offsets from the BAR base.
  localparam logic [4:0] OFF_ID          = 5'h00;
  localparam logic [4:0] OFF_GPIO_IN     = 5'h04;
  localparam logic [4:0] OFF_GPIO_OUT    = 5'h08;
  localparam logic [4:0] OFF_IRQ_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_IRQ_MASK    = 5'h10;
  localparam logic [4:0] OFF_TX_DATA     = 5'h14;
  localparam logic [4:0] OFF_FIFO_STATUS = 5'h18;
  localparam logic [4:0] OFF_RX_DATA     = 5'h1C;

  // Fixed read values.
  localparam logic [31:0] ID_VALUE  = 32'hA1B0_0002;
  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

  // FIFO_STATUS bit positions; the level field sits at the bottom of the word.
  localparam int FS_RX_OVR_BIT = 31;
  localparam int FS_FULL_BIT   = 17;
  localparam int FS_EMPTY_BIT  = 16;

  // TX_DATA read word for a popped byte: bit 31 flags that the byte is valid.
  function automatic logic [31:0] tx_word(input logic [7:0] b);
    return {1'b1, 23'b0, b};
  endfunction

endpackage

// File: rtl/bar_sync_fifo.sv
// Purpose: single-clock FIFO with level count; head is visible combinationally while not empty.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is ignored while full and pop is ignored while empty.
module bar_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and level update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; reset empties the FIFO regardless of stored contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array is data-only and carries no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bar_mmio_bridge.sv
// Purpose: host BAR MMIO register window bridging GPIO, interrupts and a byte channel each way to the SoC.
// Latency: every accepted request gets a one-cycle rsp_valid pulse exactly one cycle after accept.
// Backpressure: req_ready drops while a response is out; SoC TX stalls when the FIFO is full.
module bar_mmio_bridge
  import bar_bridge_pkg::*;
#(
  parameter int          GPIO_W     = 32,
  parameter int          N_IRQ      = 3,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  input  logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_in,
  input  logic [N_IRQ-1:0]  irq_src,
  output logic              host_irq,
  input  logic              soc_tx_valid,
  output logic              soc_tx_ready,
  input  logic [7:0]        soc_tx_data,
  output logic              soc_rx_valid,
  input  logic              soc_rx_ready,
  output logic [7:0]        soc_rx_data
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Response and register state
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [GPIO_W-1:0] gpio_in_q, gpio_in_d;
  logic [N_IRQ-1:0]  irq_status_q, irq_status_d;
  logic [N_IRQ-1:0]  irq_mask_q, irq_mask_d;
  logic [N_IRQ-1:0]  irq_prev_q, irq_prev_d;
  logic              host_irq_q, host_irq_d;
  logic              rx_vld_q, rx_vld_d;
  logic [7:0]        rx_dat_q, rx_dat_d;
  logic              rx_ovr_q, rx_ovr_d;

  // Decode results
  logic              req_acc;
  logic [31:0]       addr_off;
  logic [4:0]        reg_off;
  logic              addr_ok;
  logic [N_IRQ-1:0]  irq_clr;
  logic [N_IRQ-1:0]  irq_rise;
  logic              tx_pop;
  logic              rx_wr;
  logic              rx_ovr_clr;
  logic [31:0]       fifo_status;

  // FIFO interface
  logic              fifo_push;
  logic [7:0]        fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  assign req_ready = !rsp_valid_q;
  assign req_acc   = req_valid && req_ready;

  // Unsigned subtraction folds "below base" into a large offset, so one compare covers both ends.
  assign addr_off = req_addr - BASE_ADDR;
  assign reg_off  = addr_off[4:0];
  assign addr_ok  = (addr_off < WINDOW_BYTES) && (req_addr[1:0] == 2'b00);

  assign soc_tx_ready = !fifo_full;
  assign fifo_push    = soc_tx_valid && soc_tx_ready;

  bar_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (soc_tx_data),
    .pop       (tx_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Assemble the FIFO_STATUS read word.
  always_comb begin
    fifo_status                = '0;
    fifo_status[FS_RX_OVR_BIT] = rx_ovr_q;
    fifo_status[FS_FULL_BIT]   = fifo_full;
    fifo_status[FS_EMPTY_BIT]  = fifo_empty;
    fifo_status[LVL_W-1:0]     = fifo_level;
  end

  // Request decode: response word plus register side effects for the accepted request.
  always_comb begin
    rsp_valid_d = req_acc;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    gpio_in_d   = gpio_in_q;
    irq_mask_d  = irq_mask_q;
    irq_clr     = '0;
    tx_pop      = 1'b0;
    rx_wr       = 1'b0;
    rx_ovr_clr  = 1'b0;
    if (req_acc) begin
      if (!addr_ok) begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = ERR_RDATA;
      end else if (req_write) begin
        case (reg_off)
          OFF_GPIO_IN:     gpio_in_d  = req_wdata[GPIO_W-1:0];
          OFF_IRQ_STATUS:  irq_clr    = req_wdata[N_IRQ-1:0];
          OFF_IRQ_MASK:    irq_mask_d = req_wdata[N_IRQ-1:0];
          OFF_FIFO_STATUS: rx_ovr_clr = req_wdata[FS_RX_OVR_BIT];
          OFF_RX_DATA: begin
            rx_wr     = 1'b1;
            // A byte still held and not being consumed this cycle is dropped.
            rsp_err_d = rx_vld_q && !soc_rx_ready;
          end
          default: ; // read-only registers ignore writes silently
        endcase
      end else begin
        case (reg_off)
          OFF_ID:          rsp_rdata_d = ID_VALUE;
          OFF_GPIO_IN:     rsp_rdata_d[GPIO_W-1:0] = gpio_in_q;
          OFF_GPIO_OUT:    rsp_rdata_d[GPIO_W-1:0] = gpio_out;
          OFF_IRQ_STATUS:  rsp_rdata_d[N_IRQ-1:0]  = irq_status_q;
          OFF_IRQ_MASK:    rsp_rdata_d[N_IRQ-1:0]  = irq_mask_q;
          OFF_TX_DATA: begin
            // Empty flag is sampled before this cycle's push, so a same-cycle push is not seen.
            if (!fifo_empty) begin
              rsp_rdata_d = tx_word(fifo_head);
              tx_pop      = 1'b1;
            end
          end
          OFF_FIFO_STATUS: rsp_rdata_d = fifo_status;
          default: ; // RX_DATA reads as zero
        endcase
      end
    end
  end

  // Interrupt edge detect, W1C with set priority, and registered masked summary.
  always_comb begin
    irq_prev_d   = irq_src;
    irq_rise     = irq_src & ~irq_prev_q;
    irq_status_d = (irq_status_q & ~irq_clr) | irq_rise;
    host_irq_d   = |(irq_status_q & irq_mask_q);
  end

  // Host-to-SoC holding register: consume on ready, reload on write, flag overrun on drop.
  always_comb begin
    rx_vld_d = rx_vld_q;
    rx_dat_d = rx_dat_q;
    rx_ovr_d = rx_ovr_q;
    if (rx_vld_q && soc_rx_ready) rx_vld_d = 1'b0;
    if (rx_wr) begin
      if (!rx_vld_q || soc_rx_ready) begin
        rx_dat_d = req_wdata[7:0];
        rx_vld_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
    if (rx_ovr_clr) rx_ovr_d = 1'b0;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      gpio_in_q    <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      irq_prev_q   <= '0;
      host_irq_q   <= 1'b0;
      rx_vld_q     <= 1'b0;
      rx_dat_q     <= '0;
      rx_ovr_q     <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      gpio_in_q    <= gpio_in_d;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      irq_prev_q   <= irq_prev_d;
      host_irq_q   <= host_irq_d;
      rx_vld_q     <= rx_vld_d;
      rx_dat_q     <= rx_dat_d;
      rx_ovr_q     <= rx_ovr_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign gpio_in      = gpio_in_q;
  assign host_irq     = host_irq_q;
  assign soc_rx_valid = rx_vld_q;
  assign soc_rx_data  = rx_dat_q;

endmodule

// File: tb/tb_bar_mmio_bridge.sv
// Purpose: directed self-checking bench for bar_mmio_bridge.
// Latency: inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Backpressure: requests are issued one at a time, each waiting out its response pulse.
module tb_bar_mmio_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] gpio_out, gpio_in;
  logic [2:0]  irq_src;
  logic        host_irq;
  logic        soc_tx_valid, soc_tx_ready;
  logic [7:0]  soc_tx_data;
  logic        soc_rx_valid, soc_rx_ready;
  logic [7:0]  soc_rx_data;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] rd;
  logic        re;
  logic [31:0] snap_gpio;
  logic        snap_rx_vld;
  logic [7:0]  snap_rx_dat;

  always #5 clock = ~clock;

  bar_mmio_bridge #(
    .GPIO_W     (32),
    .N_IRQ      (3),
    .FIFO_DEPTH (8),
    .BASE_ADDR  (32'h1000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .gpio_out     (gpio_out),
    .gpio_in      (gpio_in),
    .irq_src      (irq_src),
    .host_irq     (host_irq),
    .soc_tx_valid (soc_tx_valid),
    .soc_tx_ready (soc_tx_ready),
    .soc_tx_data  (soc_tx_data),
    .soc_rx_valid (soc_rx_valid),
    .soc_rx_ready (soc_rx_ready),
    .soc_rx_data  (soc_rx_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One request: accept on the next edge, capture the response one cycle later.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    chk("req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid    = 1'b0;
    soc_tx_valid = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    rd          = rsp_rdata;
    re          = rsp_err;
    snap_gpio   = gpio_in;
    snap_rx_vld = soc_rx_valid;
    snap_rx_dat = soc_rx_data;
    step();
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    gpio_out = '0; irq_src = '0; soc_tx_valid = 1'b0; soc_tx_data = '0; soc_rx_ready = 1'b0;
    step(); step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_tx_ready", 32'(soc_tx_ready), 32'd1);
    chk("rst_gpio_in", gpio_in, 32'd0);
    chk("rst_host_irq", 32'(host_irq), 32'd0);
    chk("rst_rx_valid", 32'(soc_rx_valid), 32'd0);
    reset = 1'b0;
    step();

    // ID, GPIO and address checks
    bus(1'b0, 32'h1000, 32'h0);
    chk("id_rdata", rd, 32'hA1B0_0002); chk("id_err", 32'(re), 32'd0);
    bus(1'b1, 32'h1004, 32'h0000_00A5);
    chk("gpio_wr_rdata", rd, 32'd0); chk("gpio_in_1cyc", snap_gpio, 32'hA5);
    bus(1'b0, 32'h1004, 32'h0);
    chk("gpio_rd", rd, 32'hA5);
    bus(1'b0, 32'h1003, 32'h0);
    chk("misalign_err", 32'(re), 32'd1); chk("misalign_rdata", rd, 32'hDEADBEEF);
    bus(1'b0, 32'h1020, 32'h0);
    chk("above_err", 32'(re), 32'd1); chk("above_rdata", rd, 32'hDEADBEEF);
    bus(1'b0, 32'h0FFC, 32'h0);
    chk("below_err", 32'(re), 32'd1);
    bus(1'b1, 32'h1006, 32'hFF);
    chk("badwr_err", 32'(re), 32'd1); chk("badwr_gpio", gpio_in, 32'hA5);
    bus(1'b1, 32'h1000, 32'h1234);
    chk("ro_wr_err", 32'(re), 32'd0); chk("ro_wr_rdata", rd, 32'd0);
    bus(1'b0, 32'h1000, 32'h0);
    chk("id_after_wr", rd, 32'hA1B0_0002);
    gpio_out = 32'h1234_5678;
    bus(1'b0, 32'h1008, 32'h0);
    chk("gpio_out_rd", rd, 32'h1234_5678);

    // Interrupts
    bus(1'b1, 32'h1010, 32'h2);
    irq_src = 3'b010;
    step();
    chk("host_irq_lag", 32'(host_irq), 32'd0);
    irq_src = 3'b000;
    step();
    chk("host_irq_set", 32'(host_irq), 32'd1);
    bus(1'b0, 32'h100C, 32'h0);
    chk("irq_status", rd, 32'h2);
    irq_src = 3'b010;
    bus(1'b1, 32'h100C, 32'h2);
    bus(1'b0, 32'h100C, 32'h0);
    chk("irq_set_wins", rd, 32'h2);
    bus(1'b1, 32'h100C, 32'h2);
    bus(1'b0, 32'h100C, 32'h0);
    chk("irq_w1c", rd, 32'h0);
    chk("host_irq_clr", 32'(host_irq), 32'd0);
    irq_src = 3'b011;
    step(); step();
    chk("host_irq_masked", 32'(host_irq), 32'd0);
    bus(1'b0, 32'h100C, 32'h0);
    chk("irq_unmasked_bit", rd, 32'h1);
    irq_src = 3'b000;

    // SoC-to-host FIFO
    for (int i = 0; i < 8; i++) begin
      soc_tx_valid = 1'b1;
      soc_tx_data  = 8'(8'h10 + i);
      chk("tx_ready_fill", 32'(soc_tx_ready), 32'd1);
      step();
    end
    soc_tx_valid = 1'b0;
    chk("tx_ready_full", 32'(soc_tx_ready), 32'd0);
    soc_tx_valid = 1'b1; soc_tx_data = 8'h99;
    step();
    soc_tx_valid = 1'b0;
    bus(1'b0, 32'h1018, 32'h0);
    chk("fs_full", rd, 32'h0002_0008);
    for (int i = 0; i < 8; i++) begin
      bus(1'b0, 32'h1014, 32'h0);
      chk("tx_pop", rd, 32'(32'h8000_0010 + i));
    end
    bus(1'b0, 32'h1014, 32'h0);
    chk("tx_empty_rd", rd, 32'd0);
    bus(1'b0, 32'h1018, 32'h0);
    chk("fs_empty", rd, 32'h0001_0000);
    soc_tx_valid = 1'b1; soc_tx_data = 8'hAA;
    step();
    soc_tx_data = 8'hBB;
    bus(1'b0, 32'h1014, 32'h0);
    chk("tx_push_pop", rd, 32'h8000_00AA);
    bus(1'b0, 32'h1018, 32'h0);
    chk("fs_level_kept", rd, 32'h0000_0001);
    bus(1'b0, 32'h1014, 32'h0);
    chk("tx_second", rd, 32'h8000_00BB);
    soc_tx_valid = 1'b1; soc_tx_data = 8'hCC;
    bus(1'b0, 32'h1014, 32'h0);
    chk("tx_push_hidden", rd, 32'd0);
    bus(1'b0, 32'h1014, 32'h0);
    chk("tx_after_hidden", rd, 32'h8000_00CC);

    // Host-to-SoC holding register
    bus(1'b1, 32'h101C, 32'h41);
    chk("rx_load_err", 32'(re), 32'd0); chk("rx_load_vld", 32'(snap_rx_vld), 32'd1);
    bus(1'b1, 32'h101C, 32'h42);
    chk("rx_ovr_err", 32'(re), 32'd1); chk("rx_kept", 32'(soc_rx_data), 32'h41);
    bus(1'b0, 32'h1018, 32'h0);
    chk("fs_ovr", rd, 32'h8001_0000);
    bus(1'b0, 32'h101C, 32'h0);
    chk("rx_rd_zero", rd, 32'd0);
    bus(1'b1, 32'h1018, 32'h8000_0000);
    bus(1'b0, 32'h1018, 32'h0);
    chk("fs_ovr_clr", rd, 32'h0001_0000);
    soc_rx_ready = 1'b1;
    step();
    soc_rx_ready = 1'b0;
    chk("rx_consumed", 32'(soc_rx_valid), 32'd0);
    bus(1'b1, 32'h101C, 32'h43);
    chk("rx_reload", 32'(snap_rx_dat), 32'h43);
    soc_rx_ready = 1'b1;
    bus(1'b1, 32'h101C, 32'h44);
    soc_rx_ready = 1'b0;
    chk("rx_swap_err", 32'(re), 32'd0);
    chk("rx_swap_vld", 32'(snap_rx_vld), 32'd1);
    chk("rx_swap_dat", 32'(snap_rx_dat), 32'h44);
    bus(1'b0, 32'h1018, 32'h0);
    chk("fs_no_ovr", rd, 32'h0001_0000);

    // Reset with traffic in flight
    bus(1'b1, 32'h101C, 32'h55);
    for (int i = 0; i < 3; i++) begin
      soc_tx_valid = 1'b1;
      soc_tx_data  = 8'(i);
      step();
    end
    soc_tx_valid = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000;
    step();
    req_valid = 1'b0;
    chk("pre_rst_rsp", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_level", 32'(dut.u_fifo.level_q), 32'd0);
    chk("mid_rst_gpio", gpio_in, 32'd0);
    chk("mid_rst_rx_vld", 32'(soc_rx_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    step();
    reset = 1'b0;
    step();
    bus(1'b0, 32'h1018, 32'h0);
    chk("post_rst_fs", rd, 32'h0001_0000);
    bus(1'b0, 32'h1000, 32'h0);
    chk("post_rst_id", rd, 32'hA1B0_0002);
    chk("post_rst_err", 32'(re), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
